// File: rtl/clock_pkg.sv
// clock_pkg: shared mode encodings and digit limits for the digital clock
package clock_pkg;
    localparam int BCD_W     = 4;
    localparam int UNITS_MAX = 9;
    localparam int TENS_MAX  = 5;
    localparam int HOUR_MAX  = 23;
    typedef enum logic [1:0] {
        MODE_RUN      = 2'd0,
        MODE_SET_HOUR = 2'd1,
        MODE_SET_MIN  = 2'd2
    } mode_t;
endpackage

// File: rtl/clock_bcd_digit.sv
// bcd_digit: single BCD counter that wraps to 0 after MAX and flags the wrap
module bcd_digit
    import clock_pkg::*;
#(
    parameter int MAX = 9
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [BCD_W-1:0] q,
    output logic             wrap
);
    assign wrap = inc && (q == BCD_W'(MAX));
    // count up on inc, returning to 0 on the increment past MAX
    always_ff @(posedge clk)
        if (clr) q <= '0;
        else if (inc) q <= wrap ? '0 : q + 1'b1;
endmodule

// File: rtl/clock_ctrl.sv
// clock_ctrl: prescaled HH:MM:SS BCD clock with hour/minute set modes
module clock_ctrl
    import clock_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             key_mode,
    input  logic             key_inc,
    output logic [BCD_W-1:0] sec_lo,
    output logic [BCD_W-1:0] sec_hi,
    output logic [BCD_W-1:0] min_lo,
    output logic [BCD_W-1:0] min_hi,
    output logic [BCD_W-1:0] hour_lo,
    output logic [BCD_W-1:0] hour_hi,
    output logic [1:0]       mode,
    output logic             tick,
    output logic             blink
);
    localparam int PW = $clog2(TICK_DIV);
    logic [PW-1:0] pre;
    mode_t st;
    logic tc, run, set_exit, sec_inc, min_inc, hour_inc, hour_wrap;
    logic sl_w, sh_w, ml_w, mh_w, hl_w, hh_w;
    assign tc        = pre == PW'(TICK_DIV - 1);
    assign run       = st == MODE_RUN;
    assign set_exit  = (st == MODE_SET_MIN) && key_mode;
    assign sec_inc   = run && tc;
    assign min_inc   = run ? sh_w : (st == MODE_SET_MIN) && key_inc && !key_mode;
    assign hour_inc  = run ? mh_w : (st == MODE_SET_HOUR) && key_inc && !key_mode;
    assign hour_wrap = (hour_inc && ({hour_hi, hour_lo} == {BCD_W'(HOUR_MAX / 10), BCD_W'(HOUR_MAX % 10)})) || hh_w;
    assign mode      = st;
    assign blink     = !run && (pre < PW'(TICK_DIV / 2));
    // one-second prescaler; restarts when leaving minute-set so the first second is whole
    always_ff @(posedge clk)
        if (clr || set_exit || tc) pre <= '0;
        else pre <= pre + 1'b1;
    // mode sequencing and registered second tick
    always_ff @(posedge clk)
        if (clr) begin
            st   <= MODE_RUN;
            tick <= 1'b0;
        end else begin
            tick <= sec_inc;
            if (key_mode) st <= (st == MODE_RUN) ? MODE_SET_HOUR : (st == MODE_SET_HOUR) ? MODE_SET_MIN : MODE_RUN;
        end
    bcd_digit #(.MAX(UNITS_MAX)) u_sec_lo (.clk(clk), .clr(clr || set_exit), .inc(sec_inc), .q(sec_lo), .wrap(sl_w));
    bcd_digit #(.MAX(TENS_MAX)) u_sec_hi (.clk(clk), .clr(clr || set_exit), .inc(sl_w), .q(sec_hi), .wrap(sh_w));
    bcd_digit #(.MAX(UNITS_MAX)) u_min_lo (.clk(clk), .clr(clr), .inc(min_inc), .q(min_lo), .wrap(ml_w));
    bcd_digit #(.MAX(TENS_MAX)) u_min_hi (.clk(clk), .clr(clr), .inc(ml_w), .q(min_hi), .wrap(mh_w));
    bcd_digit #(.MAX(UNITS_MAX)) u_hour_lo (.clk(clk), .clr(clr || hour_wrap), .inc(hour_inc), .q(hour_lo), .wrap(hl_w));
    bcd_digit #(.MAX(HOUR_MAX / 10)) u_hour_hi (.clk(clk), .clr(clr || hour_wrap), .inc(hl_w), .q(hour_hi), .wrap(hh_w));
endmodule

// File: tb/tb_clock_ctrl.sv
// tb_clock_ctrl: directed stimulus against an integer time model, checked every cycle
module tb_clock_ctrl;
    localparam int T = 4;
    logic clk = 0, clr = 1, key_mode = 0, key_inc = 0;
    logic [3:0] sec_lo, sec_hi, min_lo, min_hi, hour_lo, hour_hi;
    logic [1:0] mode;
    logic tick, blink;
    int passed = 0, total = 0;
    bit chk = 0;
    int s = 0, m = 0, h = 0, md = 0, ps = 0;
    bit etick = 0;

    clock_ctrl #(.TICK_DIV(T)) dut (
        .clk(clk), .clr(clr), .key_mode(key_mode), .key_inc(key_inc),
        .sec_lo(sec_lo), .sec_hi(sec_hi), .min_lo(min_lo), .min_hi(min_hi),
        .hour_lo(hour_lo), .hour_hi(hour_hi), .mode(mode), .tick(tick), .blink(blink)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] hms(int hh, int mm, int ss);
        return {4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic logic [23:0] disp();
        return {hour_hi, hour_lo, min_hi, min_lo, sec_hi, sec_lo};
    endfunction

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // time model in whole seconds/minutes/hours
    always @(posedge clk) begin : model
        int s2, m2, h2, md2, ps2;
        bit t2, adv;
        s2 = s; m2 = m; h2 = h; md2 = md; ps2 = ps; t2 = 0;
        if (clr) begin
            s2 = 0; m2 = 0; h2 = 0; md2 = 0; ps2 = 0;
        end else begin
            adv = (ps == T - 1);
            if (md == 0 && adv) begin
                t2 = 1;
                s2 = s + 1;
                if (s2 == 60) begin
                    s2 = 0; m2 = m + 1;
                    if (m2 == 60) begin
                        m2 = 0; h2 = (h + 1) % 24;
                    end
                end
            end else if (md == 1 && key_inc && !key_mode) h2 = (h + 1) % 24;
            else if (md == 2 && key_inc && !key_mode) m2 = (m + 1) % 60;
            ps2 = adv ? 0 : ps + 1;
            if (key_mode) begin
                if (md == 2) begin
                    s2 = 0; ps2 = 0;
                end
                md2 = (md + 1) % 3;
            end
        end
        s <= s2; m <= m2; h <= h2; md <= md2; ps <= ps2; etick <= t2;
    end

    // compare DUT against the model every cycle once reset has been applied
    always @(negedge clk) if (chk) begin
        check("digits", disp(), hms(h, m, s));
        check("mode", 24'(mode), 24'(md));
        check("tick", 24'(tick), 24'(etick));
        check("blink", 24'(blink), 24'(md != 0 && ps < T / 2));
    end

    task automatic step(input logic c, input logic km, input logic ki);
        clr = c; key_mode = km; key_inc = ki;
        @(posedge clk);
        @(negedge clk);
        clr = 0; key_mode = 0; key_inc = 0;
    endtask

    initial begin
        int nb;
        @(negedge clk);
        step(1, 0, 0);
        chk = 1;
        step(1, 0, 0);
        check("rst_digits", disp(), hms(0, 0, 0));
        check("rst_mode", 24'(mode), 24'd0);
        check("rst_tick", 24'(tick), 24'd0);
        step(0, 0, 1);
        step(0, 0, 1);
        step(0, 0, 0);
        check("no_early_tick", 24'(tick), 24'd0);
        step(0, 0, 0);
        check("first_tick", 24'({tick, sec_lo}), 24'h11);
        repeat (4) step(0, 0, 0);
        check("second_tick", 24'({tick, sec_lo}), 24'h12);
        step(0, 1, 0);
        repeat (23) step(0, 0, 1);
        check("hour_set23", 24'({hour_hi, hour_lo}), 24'h23);
        step(0, 1, 0);
        repeat (59) step(0, 0, 1);
        step(0, 1, 0);
        check("exit_set", disp(), hms(23, 59, 0));
        check("exit_mode", 24'(mode), 24'd0);
        repeat (236) step(0, 0, 0);
        check("pre_rollover", disp(), hms(23, 59, 59));
        repeat (4) step(0, 0, 0);
        check("rollover", disp(), hms(0, 0, 0));
        check("rollover_tick", 24'(tick), 24'd1);
        repeat (3) step(0, 0, 0);
        step(0, 1, 0);
        check("mode_on_tick", 24'({tick, 2'b00, mode, sec_lo}), 24'h111);
        repeat (25) step(0, 0, 1);
        check("hour_wrap25", disp(), hms(1, 0, 1));
        step(0, 1, 0);
        repeat (59) step(0, 0, 1);
        check("min59", disp(), hms(1, 59, 1));
        step(0, 0, 1);
        check("min_wrap", disp(), hms(1, 0, 1));
        nb = 0;
        repeat (8) begin
            step(0, 0, 0);
            nb += int'(blink);
        end
        check("blink_duty", 24'(nb), 24'd4);
        step(0, 1, 0);
        step(0, 1, 0);
        step(0, 1, 1);
        check("mode_inc_same", 24'(mode), 24'd2);
        check("hour_kept", 24'({hour_hi, hour_lo}), 24'h01);
        step(0, 1, 0);
        step(0, 1, 0);
        repeat (11) step(0, 0, 1);
        step(0, 1, 0);
        repeat (34) step(0, 0, 1);
        check("set_1234", disp(), hms(12, 34, 0));
        step(1, 0, 0);
        check("clr_digits", disp(), hms(0, 0, 0));
        check("clr_mode_blink", 24'({mode, blink}), 24'd0);
        repeat (6) step(0, 0, 0);
        chk = 0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
